// File: rtl/mm_sched.sv
// Round-robin job scheduler for the 8x8 matrix-vector engine: grants one requester,
// sequences clr/start, waits for done (with timeout), and returns the result.
module mm_sched #(
    parameter int NREQ    = 2,
    parameter int TIMEOUT = 64,
    parameter int DRAIN   = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    output logic [$clog2(NREQ)-1:0] sel,
    output logic                    mm_clr,
    output logic                    mm_start,
    input  logic                    mm_done,
    input  logic [8*24-1:0]         mm_c,
    output logic [NREQ-1:0]         rsp_valid,
    input  logic [NREQ-1:0]         rsp_ready,
    output logic [8*24-1:0]         rsp_data,
    output logic                    rsp_err
);

    localparam int SW = $clog2(NREQ);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam int DW = $clog2(DRAIN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_GRANT, S_CLR, S_START, S_WAIT, S_DRAIN, S_RESP
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic [SW-1:0]   ptr_q, ptr_d;
    logic [WW-1:0]   wcnt_q, wcnt_d;
    logic [DW-1:0]   dcnt_q, dcnt_d;
    logic [NREQ-1:0] req_ready_q, req_ready_d;
    logic            mm_clr_q, mm_clr_d;
    logic            mm_start_q, mm_start_d;
    logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [191:0]    rsp_data_q, rsp_data_d;
    logic            rsp_err_q, rsp_err_d;

    logic [NREQ-1:0] sel_onehot;
    logic            pick_found;
    logic [SW-1:0]   pick_idx;
    logic [SW-1:0]   cand;
    int              cand_i;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_sel_onehot
        assign sel_onehot[gi] = (sel_q == SW'(gi));
    end

    // Scan downward so the nearest set bit after the pointer is the last one written.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        cand_i     = 0;
        for (int i = NREQ; i >= 1; i--) begin
            cand_i = int'(ptr_q) + i;
            if (cand_i >= NREQ) begin
                cand_i = cand_i - NREQ;
            end
            cand = SW'(cand_i);
            if (req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        ptr_d       = ptr_q;
        wcnt_d      = wcnt_q;
        dcnt_d      = dcnt_q;
        req_ready_d = '0;
        mm_clr_d    = 1'b0;
        mm_start_d  = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (pick_found) begin
                    sel_d                 = pick_idx;
                    req_ready_d[pick_idx] = 1'b1;
                    state_d               = S_GRANT;
                end
            end
            S_GRANT: begin
                mm_clr_d = 1'b1;
                state_d  = S_CLR;
            end
            S_CLR: begin
                mm_start_d = 1'b1;
                state_d    = S_START;
            end
            S_START: begin
                wcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (wcnt_q != WW'(TIMEOUT)) begin
                    wcnt_d = wcnt_q + WW'(1);
                end
                // A done seen on the first WAIT cycle is the previous job's hold.
                if (mm_done && (wcnt_q != '0)) begin
                    dcnt_d  = '0;
                    state_d = S_DRAIN;
                end else if (wcnt_q == WW'(TIMEOUT - 1)) begin
                    rsp_err_d   = 1'b1;
                    rsp_data_d  = '0;
                    rsp_valid_d = sel_onehot;
                    state_d     = S_RESP;
                end
            end
            S_DRAIN: begin
                if (dcnt_q == DW'(DRAIN - 1)) begin
                    rsp_data_d  = mm_c;
                    rsp_err_d   = 1'b0;
                    rsp_valid_d = sel_onehot;
                    state_d     = S_RESP;
                end else if (dcnt_q != DW'(DRAIN)) begin
                    dcnt_d = dcnt_q + DW'(1);
                end
            end
            S_RESP: begin
                if (|(rsp_ready & sel_onehot)) begin
                    rsp_valid_d = '0;
                    ptr_d       = sel_q;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            ptr_q       <= SW'(NREQ - 1);
            wcnt_q      <= '0;
            dcnt_q      <= '0;
            req_ready_q <= '0;
            mm_clr_q    <= 1'b0;
            mm_start_q  <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            ptr_q       <= ptr_d;
            wcnt_q      <= wcnt_d;
            dcnt_q      <= dcnt_d;
            req_ready_q <= req_ready_d;
            mm_clr_q    <= mm_clr_d;
            mm_start_q  <= mm_start_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign sel       = sel_q;
    assign mm_clr    = mm_clr_q;
    assign mm_start  = mm_start_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_mm_sched.sv
// Scoreboard bench for mm_sched: directed jobs push expected responses, a monitor
// pops and compares on every response handshake.
module tb_mm_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [0:0]   sel;
    logic         mm_clr;
    logic         mm_start;
    logic         mm_done;
    logic [191:0] mm_c;
    logic [1:0]   rsp_valid;
    logic [1:0]   rsp_ready;
    logic [191:0] rsp_data;
    logic         rsp_err;

    int           n_vec = 0;
    int           n_err = 0;
    int           eng_delay = -1;
    bit           eng_stale = 1'b0;
    logic [194:0] exp_q[$];
    logic [194:0] mon_e;
    int           cdel[4] = '{5, 10, 3, 7};

    mm_sched #(.NREQ(2), .TIMEOUT(64), .DRAIN(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .sel      (sel),
        .mm_clr   (mm_clr),
        .mm_start (mm_start),
        .mm_done  (mm_done),
        .mm_c     (mm_c),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic chk_v(input string name, input logic [191:0] act, input logic [191:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Response monitor: one scoreboard pop per handshake.
    always @(negedge clk) begin
        if (rst_n && ((rsp_valid & rsp_ready) != 2'b00)) begin
            if (exp_q.size() == 0) begin
                chk_i("unexpected_rsp", int'(rsp_valid), 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk_i("rsp_index", int'(rsp_valid), int'(mon_e[193:192]));
                chk_v("rsp_data", rsp_data, mon_e[191:0]);
                chk_i("rsp_err", int'(rsp_err), int'(mon_e[194]));
            end
        end
    end

    // Engine model: done pulse eng_delay cycles after start, or the stale-done pattern.
    initial begin
        mm_done = 1'b0;
        forever begin
            @(negedge clk);
            if (eng_stale && mm_clr) begin
                @(posedge clk); #1 mm_done = 1'b1;
                repeat (2) tick();
                mm_done = 1'b0;
                repeat (19) tick();
                mm_done = 1'b1;
                tick();
                mm_done = 1'b0;
            end else if (!eng_stale && mm_start && eng_delay >= 0) begin
                repeat (eng_delay) @(posedge clk);
                #1 mm_done = 1'b1;
                tick();
                mm_done = 1'b0;
            end
        end
    end

    task automatic do_job(input logic [1:0] rv, input bit keep, input int g, input int delay,
                          input bit stale, input int bp, input int off, input bit exp_err,
                          input int exp_lat, input int exp_gwait);
        logic [191:0] dv;
        logic [191:0] snap_d;
        logic [1:0]   gm;
        logic [1:0]   snap_v;
        int           n;
        int           bad;
        gm = (g == 0) ? 2'b01 : 2'b10;
        for (int i = 0; i < 8; i++) begin
            mm_c[24*i +: 24] = 24'(i * 100 + off);
            dv[24*i +: 24]   = exp_err ? 24'd0 : 24'(i * 100 + off);
        end
        eng_delay = delay;
        eng_stale = stale;
        rsp_ready = (bp > 0) ? ~gm : 2'b11;
        exp_q.push_back({exp_err, gm, dv});
        req_valid = rv;
        n = 0;
        while (req_ready == 2'b00 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            chk_i("grant_seen", 0, 1);
            return;
        end
        chk_i("req_ready", int'(req_ready), int'(gm));
        chk_i("sel_grant", int'(sel), g);
        if (exp_gwait >= 0) chk_i("grant_gap", n, exp_gwait);
        if (!keep) req_valid = rv & ~gm;
        tick();
        chk_i("req_ready_pulse", int'(req_ready), 0);
        chk_i("mm_clr", int'(mm_clr), 1);
        tick();
        chk_i("mm_start", int'({mm_clr, mm_start}), 1);
        n = 0;
        bad = 0;
        while (rsp_valid == 2'b00 && n < 200) begin
            tick();
            n++;
            if (sel !== 1'(g) || mm_start || mm_clr || req_ready != 2'b00) bad++;
        end
        chk_i("latency", n, exp_lat);
        chk_i("job_stable", bad, 0);
        chk_i("rsp_valid", int'(rsp_valid), int'(gm));
        if (bp > 0) begin
            snap_d = rsp_data;
            snap_v = rsp_valid;
            bad = 0;
            repeat (bp) begin
                tick();
                if (rsp_valid !== snap_v || rsp_data !== snap_d || sel !== 1'(g) ||
                    mm_start || req_ready != 2'b00) bad++;
            end
            chk_i("backpressure_hold", bad, 0);
            rsp_ready = 2'b11;
        end
        tick();
        chk_i("rsp_valid_drop", int'(rsp_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = 2'b11;
        rsp_ready = 2'b11;
        mm_c      = '0;
        repeat (3) tick();
        chk_i("rst_req_ready", int'(req_ready), 0);
        chk_i("rst_rsp_valid", int'(rsp_valid), 0);
        chk_i("rst_sel", int'(sel), 0);
        chk_i("rst_clr_start_err", int'({mm_clr, mm_start, rsp_err}), 0);
        chk_v("rst_rsp_data", rsp_data, '0);
        rst_n = 1'b1;

        // Contention: both requesting from reset, grants alternate 0,1,0,1.
        for (int j = 0; j < 4; j++) begin
            do_job(2'b11, 1'b1, j % 2, cdel[j], 1'b0, 0, 11 * j + 1, 1'b0, cdel[j] + 3, 1);
        end
        req_valid = 2'b00;

        do_job(2'b01, 1'b0, 0, 30, 1'b0, 0, 0, 1'b0, 33, -1);   // single job
        do_job(2'b11, 1'b0, 1, 8, 1'b0, 10, 7, 1'b0, 11, -1);   // backpressure
        do_job(2'b01, 1'b0, 0, 0, 1'b1, 0, 3, 1'b0, 24, -1);    // stale done
        do_job(2'b10, 1'b0, 1, -1, 1'b0, 0, 0, 1'b1, 65, -1);   // timeout
        do_job(2'b01, 1'b0, 0, 12, 1'b0, 0, 5, 1'b0, 15, -1);   // recovery

        // Reset in the middle of WAIT for a requester-1 job.
        eng_delay = -1;
        eng_stale = 1'b0;
        req_valid = 2'b10;
        n = 0;
        while (!mm_start && n < 20) begin
            tick();
            n++;
            if (req_ready != 2'b00) req_valid = 2'b00;
        end
        chk_i("abort_job_started", int'(mm_start), 1);
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        chk_i("arst_sel", int'(sel), 0);
        chk_v("arst_rsp_data", rsp_data, '0);
        chk_i("arst_ctrl", int'({req_ready, rsp_valid, mm_clr, mm_start, rsp_err}), 0);
        repeat (3) tick();
        req_valid = 2'b10;
        rst_n = 1'b1;
        do_job(2'b10, 1'b0, 1, 20, 1'b0, 0, 9, 1'b0, 23, 1);
        repeat (5) tick();
        chk_i("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mm_sched.md
Name: mm_sched

Overview:
Job scheduler and sequencer for the 8x8 matrix-vector multiply engine. It arbitrates round-robin among NREQ requesters and steers the engine's a_data/b_data input mux through sel. For each granted job it issues clr then start, waits for done (with timeout), captures c_out, and returns the result to the owning requester over a valid/ready response channel.

Parameters:
NREQ, 2, number of requesters (2..8)
TIMEOUT, 64, maximum WAIT cycles before a job is aborted with error
DRAIN, 2, cycles between observing mm_done and capturing mm_c (MAC output settle)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
req_valid  in  NREQ  job request per requester; held until accepted
req_ready  out  NREQ  one-hot acceptance pulse, one cycle
sel  out  $clog2(NREQ)  index of the requester whose data drives the engine
mm_clr  out  1  engine accumulator clear, one-cycle pulse
mm_start  out  1  engine start, one-cycle pulse
mm_done  in  1  engine done
mm_c  in  8x24  engine c_out[0:7]
rsp_valid  out  NREQ  one-hot response valid
rsp_ready  in  NREQ  response accept per requester
rsp_data  out  8x24  captured result vector
rsp_err  out  1  response is a timeout abort

Behaviour:
- Reset (async, active-low): state IDLE; req_ready, rsp_valid, mm_clr, mm_start, rsp_err = 0; rsp_data = 0; sel = 0; last-grant pointer = NREQ-1, so requester 0 has top priority first; counters = 0.
- All outputs are registered or decoded from the state register only (Moore). No input-to-output combinational paths.
- States: IDLE, GRANT, CLR, START, WAIT, DRAIN, RESP.
- IDLE: if any req_valid, pick the first set bit scanning upward from pointer+1 (mod NREQ). Load sel and go to GRANT. Otherwise stay.
- GRANT: req_ready[sel]=1 for exactly this cycle -> CLR.
- CLR: mm_clr=1 -> START.
- START: mm_start=1 -> WAIT. Clear the timeout counter.
- WAIT: counter increments each cycle.
  - mm_done is ignored on the first WAIT cycle; a stale done from the previous job's DONE hold must not complete the new job.
  - From the 2nd cycle on, mm_done=1 -> DRAIN with drain counter=0.
  - If the counter reaches TIMEOUT first -> RESP with rsp_err=1 and rsp_data=0.
  - If done and timeout coincide, done wins.
- DRAIN: wait DRAIN cycles. On the last one, rsp_data <= mm_c and rsp_err <= 0 -> RESP.
- RESP: rsp_valid[sel]=1. rsp_data, rsp_err and sel are held stable until rsp_ready[sel]=1. On that cycle: rsp_valid drops next cycle, pointer <= sel, state -> IDLE. rsp_ready on other indices is ignored.
- sel is constant from GRANT through RESP exit; the engine reads a_data/b_data over its FILL phase.
- Only one job is in flight. req_valid arriving while not IDLE waits; no grant is issued.
- A requester dropping req_valid before grant is simply not selected. Dropping it after grant has no effect on the job.
- Minimum latency, req_valid to rsp_valid: IDLE(1)+GRANT+CLR+START+WAIT(>=2)+DRAIN+1.
- rst_n asserted mid-job aborts immediately to the reset values above. No response is issued for the aborted job.
- Back-to-back: the earliest next GRANT is 2 cycles after the RESP handshake (RESP -> IDLE -> GRANT).
- Counter widths: $clog2(TIMEOUT+1) and $clog2(DRAIN+1). No wrap; each counter saturates at its terminal value.

Test Plan:
- Single job: req_valid=01, engine model asserts mm_done 30 cycles after mm_start, mm_c[i]=i*100.
  -> req_ready=01 one cycle, sel=0, mm_clr then mm_start one cycle each.
  -> rsp_valid=01 with rsp_data[i]=i*100 and rsp_err=0, DRAIN+1 cycles after done.
- Contention: req_valid=11 held from reset.
  -> grants alternate 0,1,0,1 across four jobs. sel matches the granted index for the whole job.
- Backpressure: rsp_ready low 10 cycles in RESP.
  -> rsp_valid/rsp_data/sel stable. No req_ready pulse. mm_start stays 0.
- Stale done: mm_done held 1 through START and the first WAIT cycle, then 0, then 1 at WAIT cycle 20.
  -> DRAIN entered only after cycle 20.
- Timeout: mm_done never asserted.
  -> RESP after exactly 64 WAIT cycles with rsp_err=1 and rsp_data=0. The next job proceeds normally.
- Reset mid-WAIT: rst_n low 3 cycles.
  -> all outputs 0 asynchronously. After release with req_valid=10, requester 1 is granted and no response for the aborted job appears.
